// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle used to connect a master/interconnect to the
// register slave.
//   slave  modport : AW/W/AR payload + valids and B/R readies in;
//                    AW/W/AR readies and B/R responses out.
//   master modport : the mirror image.
interface axi4lite_intf_ #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID,    output WREADY,
        output BRESP, BVALID,           input  BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID,    input  RREADY
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID,    input  WREADY,
        input  BRESP, BVALID,           output BREADY,
        output ARADDR, ARPROT, ARVALID, input  ARREADY,
        input  RDATA, RRESP, RVALID,    output RREADY
    );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: a flat array of NUM_REGS software-visible
// registers. Bus writes become byte-strobed register updates plus a
// one-cycle wr_pulse; bus reads become single-beat responses plus a
// one-cycle rd_pulse. Registers flagged in RO_MASK read back reg_in.
//   ACLK, ARESETn : clock, synchronous active-low reset
//   s_axi         : AXI4-Lite slave port
//   reg_out       : writable register contents, register i in slice i
//   reg_in        : status values returned by read-only registers
//   wr_pulse      : register i written with OKAY (one cycle)
//   rd_pulse      : register i read with OKAY (one cycle)
module axi4lite_reg_slave #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axi4lite_intf_.slave                   s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned DEC_W  = IDX_W + OFF_W;

    localparam logic [0:0] W_COLLECT = 1'b0;
    localparam logic [0:0] W_RESP    = 1'b1;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_RESP    = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_arr_t;

    reg_arr_t regs_q, regs_d;
    reg_arr_t reg_in_a;

    // write channel state
    logic [0:0]            wstate_q, wstate_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

    // read channel state
    logic [0:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] aw_addr_eff;
    logic [DATA_WIDTH-1:0] wdata_eff;
    logic [STRB_W-1:0]     wstrb_eff;
    logic [IDX_W-1:0]      w_idx, r_idx;
    logic                  w_oor, r_oor;

    assign reg_in_a = reg_in;

    assign aw_hs = awready_q && s_axi.AWVALID;
    assign w_hs  = wready_q  && s_axi.WVALID;
    assign ar_hs = arready_q && s_axi.ARVALID;

    // A held beat takes priority; its ready is low, so no live handshake competes.
    assign aw_addr_eff = aw_held_q ? awaddr_q : s_axi.AWADDR;
    assign wdata_eff   = w_held_q  ? wdata_q  : s_axi.WDATA;
    assign wstrb_eff   = w_held_q  ? wstrb_q  : s_axi.WSTRB;

    assign w_idx = aw_addr_eff[DEC_W-1:OFF_W];
    assign w_oor = |aw_addr_eff[ADDR_WIDTH-1:DEC_W];
    assign r_idx = s_axi.ARADDR[DEC_W-1:OFF_W];
    assign r_oor = |s_axi.ARADDR[ADDR_WIDTH-1:DEC_W];

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT,
                           aw_addr_eff[OFF_W-1:0], s_axi.ARADDR[OFF_W-1:0]};

    always_comb begin
        wstate_d   = wstate_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        case (wstate_q)
            W_COLLECT: begin
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    // Held flags stay set through W_RESP, keeping both readies low.
                    aw_held_d = 1'b1;
                    w_held_d  = 1'b1;
                    bvalid_d  = 1'b1;
                    wstate_d  = W_RESP;
                    if (w_oor) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d = RESP_OKAY;
                        if (!RO_MASK[w_idx]) begin
                            for (int unsigned b = 0; b < STRB_W; b++) begin
                                if (wstrb_eff[b]) begin
                                    regs_d[w_idx][b*8 +: 8] = wdata_eff[b*8 +: 8];
                                end
                            end
                            wr_pulse_d[w_idx] = 1'b1;
                        end
                    end
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = s_axi.AWADDR;
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_axi.WDATA;
                        wstrb_d  = s_axi.WSTRB;
                    end
                end
            end
            default: begin
                if (s_axi.BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_COLLECT;
                end
            end
        endcase
        awready_d = (wstate_d == W_COLLECT) && !aw_held_d;
        wready_d  = (wstate_d == W_COLLECT) && !w_held_d;
    end

    // Reads see regs_q, so a read on the same edge as a write gets the old value.
    always_comb begin
        rstate_d   = rstate_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d = 1'b1;
                    rstate_d = R_RESP;
                    if (r_oor) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rdata_d = RO_MASK[r_idx] ? reg_in_a[r_idx] : regs_q[r_idx];
                        rresp_d = RESP_OKAY;
                        rd_pulse_d[r_idx] = 1'b1;
                    end
                end
            end
            default: begin
                if (s_axi.RREADY) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            regs_q     <= {NUM_REGS{RESET_VAL}};
            wstate_q   <= W_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wstate_q   <= wstate_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rstate_q   <= rstate_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

    assign reg_out  = regs_q;
    assign wr_pulse = wr_pulse_q;
    assign rd_pulse = rd_pulse_q;
endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: 16 x 32-bit registers,
// register 0 read-only, writable registers reset to 0x1111_2222.
module tb_axi4lite_reg_slave;
    localparam int NR = 16;
    localparam int DW = 32;
    localparam logic [31:0] RV     = 32'h1111_2222;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic            clk;
    logic            rstn;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] reg_in;
    logic [NR-1:0]   wr_pulse;
    logic [NR-1:0]   rd_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    axi4lite_intf_ #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    axi4lite_reg_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .NUM_REGS  (16),
        .RO_MASK   (16'h0001),
        .RESET_VAL (RV)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rstn),
        .s_axi   (bus),
        .reg_out (reg_out),
        .reg_in  (reg_in),
        .wr_pulse(wr_pulse),
        .rd_pulse(rd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rslice(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic [15:0] exp_pulse);
        int c = 0;
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
        while (!(bus.AWREADY && bus.WREADY) && c < 16) begin tick(); c++; end
        chk({tag, "_ready"}, 64'(bus.AWREADY && bus.WREADY), 1);
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        chk({tag, "_bvalid"}, bus.BVALID, 1);
        chk({tag, "_bresp"}, bus.BRESP, exp_resp);
        chk({tag, "_wr_pulse"}, wr_pulse, exp_pulse);
        chk({tag, "_awready_lo"}, bus.AWREADY, 0);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk({tag, "_bvalid_clr"}, bus.BVALID, 0);
        chk({tag, "_wr_pulse_clr"}, wr_pulse, 0);
        chk({tag, "_ready_back"}, 64'(bus.AWREADY && bus.WREADY), 1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
        int c = 0;
        bus.ARADDR = addr; bus.ARVALID = 1'b1;
        while (!bus.ARREADY && c < 16) begin tick(); c++; end
        chk({tag, "_arready"}, bus.ARREADY, 1);
        tick();
        bus.ARVALID = 1'b0;
        chk({tag, "_rvalid"}, bus.RVALID, 1);
        chk({tag, "_rdata"}, bus.RDATA, exp_data);
        chk({tag, "_rresp"}, bus.RRESP, exp_resp);
        chk({tag, "_rd_pulse"}, rd_pulse, exp_pulse);
        chk({tag, "_arready_lo"}, bus.ARREADY, 0);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        chk({tag, "_rvalid_clr"}, bus.RVALID, 0);
        chk({tag, "_rd_pulse_clr"}, rd_pulse, 0);
        chk({tag, "_arready_back"}, bus.ARREADY, 1);
    endtask

    initial begin
        logic [NR*DW-1:0] snap;
        for (int i = 0; i < NR; i++)
            reg_in[i*32 +: 32] = (i == 0) ? 32'h0000_CAFE : (32'hEE00_0000 | 32'(i));
        rstn = 1'b0;
        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_awready", bus.AWREADY, 0);
        chk("rst_wready", bus.WREADY, 0);
        chk("rst_arready", bus.ARREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_bresp", bus.BRESP, 0);
        chk("rst_rresp", bus.RRESP, 0);
        chk("rst_rdata", bus.RDATA, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_rd_pulse", rd_pulse, 0);
        for (int i = 1; i < NR; i++) chk($sformatf("rst_reg%0d", i), rslice(i), RV);
        rstn = 1'b1;
        tick();
        chk("post_rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        // read every register after reset
        for (int i = 0; i < NR; i++)
            do_read($sformatf("rd_rst%0d", i), 32'(i*4), (i == 0) ? 32'h0000_CAFE : RV,
                    OKAY, 16'(1 << i));

        // byte-strobed write to register 2 after clearing it
        do_write("clr2", 32'h08, 32'h0, 4'hF, OKAY, 16'h0004);
        chk("clr2_val", rslice(2), 32'h0);
        do_write("strb2", 32'h08, 32'hDEAD_BEEF, 4'b0101, OKAY, 16'h0004);
        chk("strb2_val", rslice(2), 32'h00AD_00EF);
        do_read("rd2_off", 32'h0B, 32'h00AD_00EF, OKAY, 16'h0004);

        // zero strobe: OKAY with pulse, data unchanged
        do_write("strb0", 32'h10, 32'hFFFF_FFFF, 4'h0, OKAY, 16'h0010);
        chk("strb0_val", rslice(4), RV);

        // W three cycles ahead of AW, then B back-pressure for five cycles
        bus.WDATA = 32'h5555_AAAA; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wfirst_wready_lo%0d", k), bus.WREADY, 0);
            chk($sformatf("wfirst_awready_hi%0d", k), bus.AWREADY, 1);
            chk($sformatf("wfirst_bvalid_lo%0d", k), bus.BVALID, 0);
            chk($sformatf("wfirst_reg5_%0d", k), rslice(5), RV);
            if (k < 2) tick();
        end
        bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
        tick();
        chk("wfirst_commit_bvalid", bus.BVALID, 1);
        chk("wfirst_commit_pulse", wr_pulse, 16'h0020);
        chk("wfirst_commit_val", rslice(5), 32'h5555_AAAA);
        // offer a new write while B is stalled; it must not be taken
        bus.AWADDR = 32'h18; bus.WDATA = 32'h6666_6666; bus.WVALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bstall_bvalid%0d", k), bus.BVALID, 1);
            chk($sformatf("bstall_readies%0d", k), {bus.AWREADY, bus.WREADY}, 2'b00);
            chk($sformatf("bstall_pulse%0d", k), wr_pulse, 0);
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk("bstall_bvalid_clr", bus.BVALID, 0);
        chk("bstall_reg6", rslice(6), RV);

        // out of range
        snap = reg_out;
        do_write("oor_wr", 32'h40, 32'hFFFF_FFFF, 4'hF, SLVERR, 16'h0);
        for (int i = 1; i < NR; i++)
            chk($sformatf("oor_reg%0d", i), rslice(i), snap[i*32 +: 32]);
        do_read("oor_rd", 32'h40, 32'h0, SLVERR, 16'h0);

        // read-only register
        do_write("ro_wr", 32'h00, 32'h0000_1234, 4'hF, OKAY, 16'h0);
        do_read("ro_rd", 32'h00, 32'h0000_CAFE, OKAY, 16'h0001);

        // read and write committing to register 3 on the same edge
        bus.AWADDR = 32'h0C; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_3333; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h0C; bus.ARVALID = 1'b1;
        chk("coll_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        chk("coll_rdata_old", bus.RDATA, RV);
        chk("coll_reg3_new", rslice(3), 32'h0000_3333);
        chk("coll_pulses", {wr_pulse, rd_pulse}, {16'h0008, 16'h0008});
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        chk("coll_valids_clr", {bus.BVALID, bus.RVALID}, 2'b00);

        // reset with B and R pending
        bus.AWADDR = 32'h1C; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_0077; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h04; bus.ARVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        chk("pend_valids", {bus.BVALID, bus.RVALID}, 2'b11);
        chk("pend_reg7", rslice(7), 32'h0000_0077);
        rstn = 1'b0;
        tick();
        chk("mrst_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        chk("mrst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
        chk("mrst_rdata", bus.RDATA, 0);
        chk("mrst_reg7", rslice(7), RV);
        chk("mrst_reg2", rslice(2), RV);
        rstn = 1'b1;
        tick();
        chk("mrst_readies_back", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        // AW held when reset hits must be discarded
        bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        chk("held_aw_awready_lo", bus.AWREADY, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("held_aw_dropped", bus.AWREADY, 1);
        bus.WDATA = 32'h0000_0088; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        chk("held_aw_no_commit", bus.BVALID, 0);
        chk("held_aw_no_pulse", wr_pulse, 0);
        chk("held_aw_reg8", rslice(8), RV);
        bus.AWADDR = 32'h24; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        chk("late_aw_bvalid", bus.BVALID, 1);
        chk("late_aw_pulse", wr_pulse, 16'h0200);
        chk("late_aw_reg9", rslice(9), 32'h0000_0088);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk("late_aw_bclr", bus.BVALID, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
